// File: rtl/pipe_mw_skid_pkg.sv
// Shared definitions for the MEM->WB stage register: default widths,
// handshake state encoding and the payload bundle layout.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_RN_W   = 5;

  // The encoding doubles as the occupancy count (0, 1, 2).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

  // Payload bundle at the default widths; field order matches the packed
  // vector used inside the stage: {wreg, m2reg, mo, alu, rn}.
  typedef struct packed {
    logic                   wreg;
    logic                   m2reg;
    logic [PIPE_DATA_W-1:0] mo;
    logic [PIPE_DATA_W-1:0] alu;
    logic [PIPE_RN_W-1:0]   rn;
  } pipe_payload_t;

  // Number of held entries for a given handshake state.
  function automatic logic [1:0] occ_of(skid_state_e s);
    logic [1:0] occ;
    case (s)
      ST_BUSY: occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_mw_skid_if.sv
// Handshake and payload bundle between MEM (upstream) and WB (downstream).
// slave = the stage register itself, master = whoever drives it.
interface pipe_mw_skid_if #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_wreg;
  logic              in_m2reg;
  logic [DATA_W-1:0] in_mo;
  logic [DATA_W-1:0] in_alu;
  logic [RN_W-1:0]   in_rn;
  logic              out_valid;
  logic              out_ready;
  logic              out_wreg;
  logic              out_m2reg;
  logic [DATA_W-1:0] out_mo;
  logic [DATA_W-1:0] out_alu;
  logic [RN_W-1:0]   out_rn;
  logic [1:0]        occupancy;

  modport slave (
    input  flush, in_valid, in_wreg, in_m2reg, in_mo, in_alu, in_rn, out_ready,
    output in_ready, out_valid, out_wreg, out_m2reg, out_mo, out_alu, out_rn,
           occupancy
  );

  modport master (
    output flush, in_valid, in_wreg, in_m2reg, in_mo, in_alu, in_rn, out_ready,
    input  in_ready, out_valid, out_wreg, out_m2reg, out_mo, out_alu, out_rn,
           occupancy
  );
endinterface

// File: rtl/pipe_mw_skid_slot.sv
// One payload slot: loads on ld_i, zeroes on clr_i (clear wins), and
// resets asynchronously to zero so an empty slot never carries stale data.
module pipe_mw_slot #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ld_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;

  // Payload register: clear has priority over load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (ld_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;
endmodule

// File: rtl/pipe_mw_skid.sv
// MEM->WB stage register with valid/ready flow control and flush.
// SKID=1: main + skid slot, registered in_ready (no comb path from out_ready).
// SKID=0: single slot, in_ready = out_ready | ~out_valid.
module pipe_mw_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int RN_W   = PIPE_RN_W,
  parameter int SKID   = 1
) (
  input  logic           clock,
  input  logic           resetn,
  pipe_mw_skid_if.slave  bus
);
  localparam int PW = 2 + 2 * DATA_W + RN_W;

  skid_state_e   state_q, state_d;
  logic          in_ready, out_valid;
  logic          in_xfer, out_xfer;
  logic          main_ld, main_clr, main_from_skid;
  logic          skid_ld, skid_clr;
  logic [PW-1:0] in_pld, main_d, main_q, skid_q;

  assign in_pld    = {bus.in_wreg, bus.in_m2reg, bus.in_mo, bus.in_alu, bus.in_rn};
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = bus.in_valid & in_ready;
  assign out_xfer  = out_valid & bus.out_ready;

  // Next state and slot controls; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (bus.flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_BUSY;
            main_ld = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            main_ld = 1'b1;
          end else if (in_xfer && (SKID != 0)) begin
            state_d = ST_FULL;
            skid_ld = 1'b1;
          end else if (out_xfer) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_d        = ST_BUSY;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // Handshake state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pld;

  pipe_mw_slot #(.W(PW)) u_main (
    .clk_i  (clock),
    .rst_ni (resetn),
    .ld_i   (main_ld),
    .clr_i  (main_clr),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  if (SKID != 0) begin : g_skid
    logic in_ready_q;

    pipe_mw_slot #(.W(PW)) u_skid (
      .clk_i  (clock),
      .rst_ni (resetn),
      .ld_i   (skid_ld),
      .clr_i  (skid_clr),
      .d_i    (in_pld),
      .q_o    (skid_q)
    );

    // Registered ready: accept next cycle unless the stage is about to be full.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= (state_d != ST_FULL);
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_noskid
    logic unused_skid;

    assign skid_q      = '0;
    assign in_ready    = bus.out_ready | ~out_valid;
    assign unused_skid = skid_ld | skid_clr;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.occupancy = occ_of(state_q);
  assign {bus.out_wreg, bus.out_m2reg, bus.out_mo, bus.out_alu, bus.out_rn} = main_q;
endmodule

// File: doc/pipe_mw_skid.md
# pipe_mw_skid

Parametrised MEM→WB pipeline stage register with valid/ready flow control, synchronous flush and an optional two-entry skid buffer. It replaces the fixed, always-enabled MEM/WB register, so the write-back stage can stall without a combinational ready path back through MEM. It carries `wreg`, `m2reg`, the memory data, the ALU result and the destination register number. Any slot that does not hold a valid instruction holds an all-zero payload, so a bubble can never write the register file.

## Interface
Parameters:
- `DATA_W`, default 32: width of the memory-data and ALU-result fields.
- `RN_W`, default 5: width of the destination register number.
- `SKID`, default 1:
  - 1 = two-entry skid buffer with registered `in_ready`.
  - 0 = single register with combinational `in_ready`.

Ports:
- `clock` in 1: rising-edge clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous kill of all held entries.
- `in_valid` in 1: MEM stage presents an instruction.
- `in_ready` out 1: stage can accept an instruction this cycle.
- `in_wreg`, `in_m2reg` in 1 each: control bits.
- `in_mo` in DATA_W: memory read data.
- `in_alu` in DATA_W: ALU result.
- `in_rn` in RN_W: destination register.
- `out_valid` out 1: WB stage holds a valid instruction.
- `out_ready` in 1: WB consumes the instruction this cycle.
- `out_wreg`, `out_m2reg` out 1 each; `out_mo`, `out_alu` out DATA_W each; `out_rn` out RN_W.
- `occupancy` out 2: number of entries held (0..2; at most 1 when SKID=0).

## Operation
- Input transfer: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- Storage:
  - A main slot drives the `out_*` ports.
  - A skid slot exists only when SKID=1.
- State machine (SKID=1):
  - EMPTY (occ 0):
    - input transfer → BUSY, main ← input.
  - BUSY (occ 1):
    - input and output transfer → BUSY, main ← input.
    - input only → FULL, skid ← input.
    - output only → EMPTY, main ← 0.
    - neither → hold.
  - FULL (occ 2): `in_ready` = 0.
    - output transfer → BUSY, main ← skid, skid ← 0.
    - no output transfer → hold.
- SKID=1 `in_ready`:
  - Registered; equals (next state != FULL).
  - Never depends combinationally on `out_ready`.
- SKID=0:
  - `in_ready = out_ready | ~out_valid` (combinational).
  - States are EMPTY and BUSY only, with the same transitions as above minus FULL.
- `out_valid` = 1 iff state != EMPTY.
- Payload zeroing: every slot that is not valid holds all-zero payload. This is required, not optional, because downstream logic uses `out_wreg` without gating it with `out_valid`.
- `flush`:
  - Highest priority; overrides any simultaneous input or output transfer.
  - Next state is EMPTY; both slots are zeroed.
  - `in_ready` returns to 1 on the next cycle.
  - An instruction presented in the flush cycle is dropped.
  - A WB consumption in the flush cycle still counts as having occurred for that cycle.
- Payload is never reordered, duplicated or dropped except by `flush`.

## Timing
- Reset (`resetn` = 0, asynchronous):
  - State EMPTY.
  - `out_valid`, `out_wreg`, `out_m2reg`, `out_mo`, `out_alu`, `out_rn` and `occupancy` are all 0.
  - `in_ready` = 1 for both SKID values.
- Reset mid-operation discards every held entry immediately, without waiting for a clock edge.
- Latency: an input accepted at edge N appears on `out_*` after edge N when the main slot is free or being drained. Otherwise it waits in the skid slot.
- Throughput:
  - One instruction per cycle while `out_ready` = 1.
  - SKID=1 absorbs exactly one extra instruction when `out_ready` drops.
- All state and outputs update only on the rising `clock` edge, except the asynchronous reset.

## Structure
- Shared package `pipe_pkg`:
  - Defaults `DATA_W` = 32 and `RN_W` = 5.
  - The skid state encoding: EMPTY = 2'b00, BUSY = 2'b01, FULL = 2'b10.
  - A packed payload bundle type {wreg, m2reg, mo, alu, rn}.
- One sub-module, `pipe_mw_slot`: a payload register with load, clear and asynchronous-reset-to-zero.
  - Instantiated once for main.
  - Instantiated once for skid under `SKID` = 1.
- Handshake FSM and `in_ready` logic live in the top module.

## Test plan
- Reset, then stream three instructions with `out_ready` = 1 (rn = 1, 2, 3; alu = 0x10, 0x20, 0x30) → outputs match one cycle after acceptance; `occupancy` is 1 throughout.
- SKID=1: `out_ready` = 0 while instructions A and B arrive → `occupancy` reaches 2 and `in_ready` = 0 for the cycle after B. Then `out_ready` = 1 → A, then B, appear in order with no loss.
- Assert `flush` while FULL with `in_valid` = 1 → next cycle `out_valid` = 0, all `out_*` = 0, `in_ready` = 1, and the presented instruction is absent from the output.
- SKID=0 with `out_valid` = 1 and `out_ready` = 0 → `in_ready` = 0 in the same cycle. Raise `out_ready` → `in_ready` = 1 combinationally and the next instruction replaces the held one at the edge.
- Deassert `resetn` asynchronously mid-cycle while BUSY with `out_wreg` = 1 → `out_wreg` and `out_valid` drop immediately; after release the first accepted instruction passes intact.
- Drain to EMPTY after an instruction with wreg = 1, rn = 31 → `out_wreg` = 0 and `out_rn` = 0 while `out_valid` = 0.
